// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 width codes, fault
// causes, FSM states and the start-time legality/alignment helpers.
package load_store_unit_pkg;

   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;

   localparam logic [1:0] LSU_FAULT_MISALIGN = 2'd0;
   localparam logic [1:0] LSU_FAULT_BUSERR   = 2'd1;
   localparam logic [1:0] LSU_FAULT_TIMEOUT  = 2'd2;
   localparam logic [1:0] LSU_FAULT_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_e;

   // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
   function automatic logic lsu_f3_legal(input logic st, input logic [2:0] f3);
      logic ok;
      case (f3)
         LSU_F3_B, LSU_F3_H, LSU_F3_W: ok = 1'b1;
         LSU_F3_BU, LSU_F3_HU:         ok = ~st;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         LSU_F3_H, LSU_F3_HU: mis = off[0];
         LSU_F3_W:            mis = (off != 2'b00);
         default:             mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_err, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_err, bus_rdata
   );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load lane select plus sign/zero extension.
module lsu_load_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword lanes out of the bus word.
   always_comb begin
      case (off_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Extend the selected lane according to the load width/sign.
   always_comb begin
      case (funct3_i)
         LSU_F3_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LSU_F3_H:  data_o = {{16{half_sel[15]}}, half_sel};
         LSU_F3_BU: data_o = {24'd0, byte_sel};
         LSU_F3_HU: data_o = {16'd0, half_sel};
         default:   data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates a request from the ALU stage, runs one bus
// transfer with a watchdog, and reports done/fault plus extended load data.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    is_store,
   input  logic [2:0]              funct3,
   input  logic [31:0]             addr,
   input  logic [31:0]             store_data,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             load_data,
   output logic                    fault,
   output logic [1:0]              fault_cause,
   load_store_unit_if.master       bus
);

   localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);
   localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);

   lsu_state_e  state_q, state_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] wdog_q, wdog_d;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] ldata_q, ldata_d;

   logic [3:0]  steer_be;
   logic [31:0] steer_wdata;
   logic [31:0] ext_data;
   logic [16:0] wdog_inc;

   lsu_load_extend u_load_extend (
      .rdata_i  (bus.bus_rdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (ext_data)
   );

   // Store lane steering: replicate the datum and enable the addressed lanes.
   always_comb begin
      case (funct3)
         LSU_F3_B: begin
            steer_wdata = {4{store_data[7:0]}};
            steer_be    = 4'b0001 << addr[1:0];
         end
         LSU_F3_H: begin
            steer_wdata = {2{store_data[15:0]}};
            steer_be    = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            steer_wdata = store_data;
            steer_be    = 4'b1111;
         end
      endcase
   end

   // Next-state logic: request checks, bus completion and watchdog.
   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      off_d    = off_q;
      we_d     = we_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      wdog_d   = wdog_q;
      fault_d  = fault_q;
      cause_d  = cause_q;
      ldata_d  = ldata_q;
      wdog_inc = {1'b0, wdog_q} + 17'd1;

      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               wdog_d = 16'd0;
               if (!lsu_f3_legal(is_store, funct3)) begin
                  fault_d = 1'b1;
                  cause_d = LSU_FAULT_ILLEGAL;
                  state_d = LSU_RESP;
               end else if (lsu_misaligned(funct3, addr[1:0])) begin
                  fault_d = 1'b1;
                  cause_d = LSU_FAULT_MISALIGN;
                  state_d = LSU_RESP;
               end else begin
                  // Bus fields only change when a real transfer begins.
                  fault_d = 1'b0;
                  f3_d    = funct3;
                  off_d   = addr[1:0];
                  we_d    = is_store;
                  addr_d  = {addr[31:2], 2'b00};
                  be_d    = is_store ? steer_be : 4'b1111;
                  wdata_d = is_store ? steer_wdata : 32'd0;
                  state_d = LSU_ACCESS;
               end
            end
         end
         LSU_ACCESS: begin
            if (bus.bus_err) begin
               fault_d = 1'b1;
               cause_d = LSU_FAULT_BUSERR;
               state_d = LSU_RESP;
            end else if (bus.bus_ack) begin
               fault_d = 1'b0;
               if (!we_q) begin
                  ldata_d = ext_data;
               end
               state_d = LSU_RESP;
            end else begin
               wdog_d = wdog_inc[15:0];
               if (TO_EN && (wdog_inc == TO_LIMIT)) begin
                  fault_d = 1'b1;
                  cause_d = LSU_FAULT_TIMEOUT;
                  state_d = LSU_RESP;
               end
            end
         end
         LSU_RESP: begin
            wdog_d  = 16'd0;
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LSU_IDLE;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         wdog_q  <= 16'd0;
         fault_q <= 1'b0;
         cause_q <= 2'd0;
         ldata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         wdog_q  <= wdog_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         ldata_q <= ldata_d;
      end
   end

   // Outputs decode directly from state so a reset drops bus_req at once.
   always_comb begin
      busy          = (state_q != LSU_IDLE);
      done          = (state_q == LSU_RESP);
      fault         = done & fault_q;
      fault_cause   = done ? cause_q : 2'd0;
      load_data     = ldata_q;
      bus.bus_req   = (state_q == LSU_ACCESS);
      bus.bus_we    = we_q;
      bus.bus_addr  = addr_q;
      bus.bus_be    = be_q;
      bus.bus_wdata = wdata_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (watchdog set to 4 cycles).
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        busy, done, fault;
   logic [31:0] load_data;
   logic [1:0]  fault_cause;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   int done_cnt;

   load_store_unit_if bus_if ();

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_store    (is_store),
      .funct3      (funct3),
      .addr        (addr),
      .store_data  (store_data),
      .busy        (busy),
      .done        (done),
      .load_data   (load_data),
      .fault       (fault),
      .fault_cause (fault_cause),
      .bus         (bus_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = d;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic bus_resp(input int nwait, input logic [31:0] rd,
                           input logic err, input logic ack);
      repeat (nwait) step();
      bus_if.bus_rdata = rd;
      bus_if.bus_err   = err;
      bus_if.bus_ack   = ack;
      step();
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_err   = 1'b0;
      bus_if.bus_rdata = 32'd0;
   endtask

   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
      do_start(1'b0, f3, a, 32'd0);
      chk({tag, "_req"}, bus_if.bus_req, 1'b1);
      chk({tag, "_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      bus_resp(0, rd, 1'b0, 1'b1);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_data"}, load_data, exp);
      step();
      chk({tag, "_hold"}, load_data, exp);
   endtask

   task automatic run_fault(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [1:0] cause,
                            input logic [31:0] ld_exp);
      do_start(st, f3, a, 32'h1111_2222);
      chk({tag, "_noreq"}, bus_if.bus_req, 1'b0);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_fault"}, fault, 1'b1);
      chk({tag, "_cause"}, fault_cause, cause);
      chk({tag, "_ld"}, load_data, ld_exp);
      step();
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_err   = 1'b0;
      bus_if.bus_rdata = 32'd0;

      // reset
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_req", bus_if.bus_req, 1'b0);
      chk("rst_ld", load_data, 32'd0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_be", bus_if.bus_be, 4'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // SW with two wait states
      do_start(1'b1, LSU_F3_W, 32'h1000_0004, 32'hDEAD_BEEF);
      chk("sw_req", bus_if.bus_req, 1'b1);
      chk("sw_busy", busy, 1'b1);
      chk("sw_addr", bus_if.bus_addr, 32'h1000_0004);
      chk("sw_be", bus_if.bus_be, 4'b1111);
      chk("sw_we", bus_if.bus_we, 1'b1);
      chk("sw_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
      step();
      step();
      chk("sw_wait_done", done, 1'b0);
      chk("sw_wait_addr", bus_if.bus_addr, 32'h1000_0004);
      bus_resp(0, 32'd0, 1'b0, 1'b1);
      chk("sw_done", done, 1'b1);
      chk("sw_fault", fault, 1'b0);
      chk("sw_req_drop", bus_if.bus_req, 1'b0);
      chk("sw_ld", load_data, 32'd0);
      step();
      chk("sw_done_pulse", done, 1'b0);
      chk("sw_idle", busy, 1'b0);

      // loads and extension
      do_start(1'b0, LSU_F3_B, 32'h2000_0003, 32'd0);
      chk("lb_we", bus_if.bus_we, 1'b0);
      chk("lb_be", bus_if.bus_be, 4'b1111);
      bus_resp(1, 32'h80FF_1234, 1'b0, 1'b1);
      chk("lb_data", load_data, 32'hFFFF_FF80);
      step();
      run_load("lbu", LSU_F3_BU, 32'h2000_0003, 32'h80FF_1234, 32'h0000_0080);
      run_load("lh", LSU_F3_H, 32'h2000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
      run_load("lhu", LSU_F3_HU, 32'h2000_0000, 32'h80FF_9234, 32'h0000_9234);
      run_load("lb1", LSU_F3_B, 32'h2000_0001, 32'h0000_7F00, 32'h0000_007F);
      run_load("lw", LSU_F3_W, 32'h2000_0008, 32'h80FF_1234, 32'h80FF_1234);

      // store lane steering
      do_start(1'b1, LSU_F3_B, 32'h3000_0001, 32'h0000_00A5);
      chk("sb_be", bus_if.bus_be, 4'b0010);
      chk("sb_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
      chk("sb_addr", bus_if.bus_addr, 32'h3000_0000);
      bus_resp(0, 32'd0, 1'b0, 1'b1);
      chk("sb_ld_keep", load_data, 32'h80FF_1234);
      step();
      do_start(1'b1, LSU_F3_H, 32'h3000_0002, 32'h0000_BEEF);
      chk("sh_be", bus_if.bus_be, 4'b1100);
      chk("sh_wdata", bus_if.bus_wdata, 32'hBEEF_BEEF);
      bus_resp(0, 32'd0, 1'b0, 1'b1);
      step();
      do_start(1'b1, LSU_F3_B, 32'h3000_0003, 32'h1234_5677);
      chk("sb3_be", bus_if.bus_be, 4'b1000);
      chk("sb3_wdata", bus_if.bus_wdata, 32'h7777_7777);
      bus_resp(0, 32'd0, 1'b0, 1'b1);
      step();

      // start-time faults
      run_fault("lw_mis", 1'b0, LSU_F3_W, 32'h4000_0002, LSU_FAULT_MISALIGN, 32'h80FF_1234);
      run_fault("lh_mis", 1'b0, LSU_F3_H, 32'h4000_0001, LSU_FAULT_MISALIGN, 32'h80FF_1234);
      run_fault("ld_f3", 1'b0, 3'b011, 32'h4000_0000, LSU_FAULT_ILLEGAL, 32'h80FF_1234);
      run_fault("st_f3", 1'b1, LSU_F3_BU, 32'h4000_0001, LSU_FAULT_ILLEGAL, 32'h80FF_1234);
      run_fault("sw_f3prio", 1'b1, 3'b110, 32'h4000_0003, LSU_FAULT_ILLEGAL, 32'h80FF_1234);

      // bus error wins over ack
      do_start(1'b0, LSU_F3_W, 32'h5000_0000, 32'd0);
      bus_resp(1, 32'h1234_5678, 1'b1, 1'b1);
      chk("err_done", done, 1'b1);
      chk("err_fault", fault, 1'b1);
      chk("err_cause", fault_cause, LSU_FAULT_BUSERR);
      chk("err_ld", load_data, 32'h80FF_1234);
      step();

      // watchdog timeout after 4 cycles
      do_start(1'b0, LSU_F3_W, 32'h6000_0000, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("to_req_hi", bus_if.bus_req, 1'b1);
         step();
      end
      chk("to_req_hi4", bus_if.bus_req, 1'b1);
      step();
      chk("to_req_drop", bus_if.bus_req, 1'b0);
      chk("to_done", done, 1'b1);
      chk("to_cause", fault_cause, LSU_FAULT_TIMEOUT);
      chk("to_fault", fault, 1'b1);
      step();

      // start while busy is ignored
      do_start(1'b0, LSU_F3_W, 32'h7000_0000, 32'd0);
      is_store = 1'b1;
      funct3   = LSU_F3_B;
      addr     = 32'h7100_0001;
      start    = 1'b1;
      step();
      start    = 1'b0;
      chk("busy_we", bus_if.bus_we, 1'b0);
      chk("busy_addr", bus_if.bus_addr, 32'h7000_0000);
      bus_resp(0, 32'hCAFE_F00D, 1'b0, 1'b1);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_cnt++;
         step();
      end
      chk("busy_one_done", done_cnt, 1);
      chk("busy_ld", load_data, 32'hCAFE_F00D);

      // reset in the middle of an access
      do_start(1'b0, LSU_F3_W, 32'h8000_0000, 32'd0);
      chk("mid_req", bus_if.bus_req, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_req_drop", bus_if.bus_req, 1'b0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_ld", load_data, 32'd0);
      #2 rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done) done_cnt++;
      end
      chk("mid_no_done", done_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
